x_ramb_asym_dp_clr: RTL and testbench

Parametrised single-clock, true dual-port block RAM. Port widths, depth, write modes and optional output registers are generics. Adds two things the fixed-width S1/S4 primitive lacks: a hardware clear sequencer that sweeps the array after reset, and deterministic same-cycle collision handling with a flag. It sits in the simprims library as the behavioural core for asymmetric RAM wrappers and PicoBlaze scratch/program memories.

---
 rtl/x_ram_pkg.sv | 28 ++
 rtl/x_ram_port_out.sv | 66 ++++++
 rtl/x_ramb_asym_dp_clr.sv | 193 +++++++++++++++++++
 tb/tb_x_ramb_asym_dp_clr.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/x_ram_pkg.sv
// Shared encodings and helpers for the x_ram behavioural memory family.
package x_ram_pkg;

    typedef enum logic [1:0] {
        WF = 2'b00,
        RF = 2'b01,
        NC = 2'b10
    } wmode_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } ram_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/x_ram_port_out.sv
// Per-port read-data path: write-mode mux, SSR handling and optional output register.
module x_ram_port_out
    import x_ram_pkg::*;
#(
    parameter int                WIDTH = 1,
    parameter wmode_t            MODE  = WF,
    parameter logic [WIDTH-1:0]  SRVAL = '0,
    parameter logic [WIDTH-1:0]  INIT  = '0,
    parameter bit                REG   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic             ssr,
    input  logic [WIDTH-1:0] di,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage1_d;

    // Select what stage 1 captures; SSR acts here only when there is no output register.
    always_comb begin
        stage1_d = stage1_q;
        if (ssr && !REG) begin
            stage1_d = SRVAL;
        end else if (we) begin
            case (MODE)
                WF:      stage1_d = di;
                RF:      stage1_d = rd_data;
                default: stage1_d = stage1_q;
            endcase
        end else begin
            stage1_d = rd_data;
        end
    end

    // Stage 1 register, updated only on enabled edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1_q <= INIT;
        end else if (en) begin
            stage1_q <= stage1_d;
        end
    end

    if (REG) begin : g_out_reg
        logic [WIDTH-1:0] out_q;

        // Output pipeline register; SSR overrides the pipelined data here.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_q <= INIT;
            end else if (en) begin
                out_q <= ssr ? SRVAL : stage1_q;
            end
        end

        assign dout = out_q;
    end else begin : g_no_reg
        assign dout = stage1_q;
    end

endmodule

// File: rtl/x_ramb_asym_dp_clr.sv
// Asymmetric true dual-port RAM with post-reset clear sweep and write-collision flag.
module x_ramb_asym_dp_clr
    import x_ram_pkg::*;
#(
    parameter int                  MEM_BITS       = 16384,
    parameter int                  WIDTH_A        = 1,
    parameter int                  WIDTH_B        = 4,
    parameter string               WRITE_MODE_A   = "WRITE_FIRST",
    parameter string               WRITE_MODE_B   = "WRITE_FIRST",
    parameter logic [WIDTH_A-1:0]  INIT_A         = '0,
    parameter logic [WIDTH_B-1:0]  INIT_B         = '0,
    parameter logic [WIDTH_A-1:0]  SRVAL_A        = '0,
    parameter logic [WIDTH_B-1:0]  SRVAL_B        = '0,
    parameter bit                  DOA_REG        = 1'b0,
    parameter bit                  DOB_REG        = 1'b0,
    parameter bit                  CLEAR_ON_RESET = 1'b1,
    parameter bit                  CLEAR_VAL      = 1'b0,
    localparam int                 AW_A           = clog2(MEM_BITS / WIDTH_A),
    localparam int                 AW_B           = clog2(MEM_BITS / WIDTH_B)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [AW_A-1:0]    ADDRA,
    input  logic [WIDTH_A-1:0] DIA,
    input  logic               ENA,
    input  logic               WEA,
    input  logic               SSRA,
    output logic [WIDTH_A-1:0] DOA,
    input  logic [AW_B-1:0]    ADDRB,
    input  logic [WIDTH_B-1:0] DIB,
    input  logic               ENB,
    input  logic               WEB,
    input  logic               SSRB,
    output logic [WIDTH_B-1:0] DOB,
    output logic               BUSY,
    output logic               COLLISION
);

    localparam int WMAX      = (WIDTH_A > WIDTH_B) ? WIDTH_A : WIDTH_B;
    localparam int BIT_AW    = clog2(MEM_BITS);
    localparam int SHIFT_A   = clog2(WIDTH_A);
    localparam int SHIFT_B   = clog2(WIDTH_B);
    localparam int SHIFT_M   = clog2(WMAX);
    localparam int WORDS_MAX = MEM_BITS / WMAX;
    localparam int CNT_W     = (clog2(WORDS_MAX) > 0) ? clog2(WORDS_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_MAX - 1);

    localparam bit MODE_A_OK = (WRITE_MODE_A == "WRITE_FIRST") ||
                               (WRITE_MODE_A == "READ_FIRST")  ||
                               (WRITE_MODE_A == "NO_CHANGE");
    localparam bit MODE_B_OK = (WRITE_MODE_B == "WRITE_FIRST") ||
                               (WRITE_MODE_B == "READ_FIRST")  ||
                               (WRITE_MODE_B == "NO_CHANGE");
    localparam wmode_t MODE_A = (WRITE_MODE_A == "READ_FIRST") ? RF :
                                (WRITE_MODE_A == "NO_CHANGE")  ? NC : WF;
    localparam wmode_t MODE_B = (WRITE_MODE_B == "READ_FIRST") ? RF :
                                (WRITE_MODE_B == "NO_CHANGE")  ? NC : WF;

    if (!MODE_A_OK || !MODE_B_OK) begin : g_bad_mode
        $fatal(1, "x_ramb_asym_dp_clr: illegal WRITE_MODE");
    end
    if (!is_pow2(MEM_BITS) || !is_pow2(WIDTH_A) || !is_pow2(WIDTH_B) ||
        WIDTH_A > 32 || WIDTH_B > 32) begin : g_bad_width
        $fatal(1, "x_ramb_asym_dp_clr: widths must be powers of two, 1..32");
    end
    if (WIDTH_A > MEM_BITS || WIDTH_B > MEM_BITS) begin : g_bad_size
        $fatal(1, "x_ramb_asym_dp_clr: port width exceeds MEM_BITS");
    end

    logic [MEM_BITS-1:0] mem;
    ram_state_t          state_q;
    ram_state_t          state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                collision_q;
    logic                ready;
    logic                en_a;
    logic                en_b;
    logic                wr_a;
    logic                wr_b;
    logic                overlap;
    logic [BIT_AW-1:0]   bit_a;
    logic [BIT_AW-1:0]   bit_b;
    logic [BIT_AW-1:0]   bit_c;
    logic [WIDTH_A-1:0]  rd_a;
    logic [WIDTH_B-1:0]  rd_b;

    assign ready = (state_q == ST_READY) && !RST;
    assign en_a  = ENA && ready;
    assign en_b  = ENB && ready;
    assign wr_a  = en_a && WEA;
    assign wr_b  = en_b && WEB;

    // Aligned power-of-two ranges overlap exactly when they share a WMAX-sized block.
    assign bit_a   = BIT_AW'(ADDRA) << SHIFT_A;
    assign bit_b   = BIT_AW'(ADDRB) << SHIFT_B;
    assign bit_c   = BIT_AW'(cnt_q) << SHIFT_M;
    assign overlap = (bit_a >> SHIFT_M) == (bit_b >> SHIFT_M);

    assign rd_a = mem[bit_a +: WIDTH_A];
    assign rd_b = mem[bit_b +: WIDTH_B];

    assign BUSY      = (state_q == ST_CLEAR);
    assign COLLISION = collision_q;

    // Sequencer state and sweep counter; reset restarts the sweep from word 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep advances one WMAX word per cycle and drops to READY after the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // Array writes: sweep, then port A, then port B so B wins on overlapping bits.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state_q == ST_CLEAR) begin
                mem[bit_c +: WMAX] <= {WMAX{CLEAR_VAL}};
            end
            if (wr_a) begin
                mem[bit_a +: WIDTH_A] <= DIA;
            end
            if (wr_b) begin
                mem[bit_b +: WIDTH_B] <= DIB;
            end
        end
    end

    // One-cycle flag for dual writes that touch the same bits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= wr_a && wr_b && overlap;
        end
    end

    x_ram_port_out #(
        .WIDTH (WIDTH_A),
        .MODE  (MODE_A),
        .SRVAL (SRVAL_A),
        .INIT  (INIT_A),
        .REG   (DOA_REG)
    ) u_port_a (
        .clk     (CLK),
        .rst     (RST),
        .en      (en_a),
        .we      (WEA),
        .ssr     (SSRA),
        .di      (DIA),
        .rd_data (rd_a),
        .dout    (DOA)
    );

    x_ram_port_out #(
        .WIDTH (WIDTH_B),
        .MODE  (MODE_B),
        .SRVAL (SRVAL_B),
        .INIT  (INIT_B),
        .REG   (DOB_REG)
    ) u_port_b (
        .clk     (CLK),
        .rst     (RST),
        .en      (en_b),
        .we      (WEB),
        .ssr     (SSRB),
        .di      (DIB),
        .rd_data (rd_b),
        .dout    (DOB)
    );

endmodule

// File: tb/tb_x_ramb_asym_dp_clr.sv
// Self-checking bench: three configurations of x_ramb_asym_dp_clr sharing clock and reset.
module tb_x_ramb_asym_dp_clr;

    logic CLK;
    logic RST;

    // Default configuration (16384 bits, 1/4 wide, write-first, clear on reset)
    logic [13:0] d0_addra;
    logic        d0_dia, d0_ena, d0_wea, d0_ssra, d0_doa;
    logic [11:0] d0_addrb;
    logic [3:0]  d0_dib, d0_dob;
    logic        d0_enb, d0_web, d0_ssrb, d0_busy, d0_col;

    // No clear, A no-change, B read-first, 64 bits
    logic [5:0]  d1_addra;
    logic        d1_dia, d1_ena, d1_wea, d1_ssra, d1_doa;
    logic [3:0]  d1_addrb;
    logic [3:0]  d1_dib, d1_dob;
    logic        d1_enb, d1_web, d1_ssrb, d1_busy, d1_col;

    // Registered B output, clear to ones, 64 bits
    logic [5:0]  d2_addra;
    logic        d2_dia, d2_ena, d2_wea, d2_ssra, d2_doa;
    logic [3:0]  d2_addrb;
    logic [3:0]  d2_dib, d2_dob;
    logic        d2_enb, d2_web, d2_ssrb, d2_busy, d2_col;

    int checks;
    int errors;

    typedef struct {
        logic       ena, wea, ssra;
        logic [5:0] addra;
        logic       dia;
        logic       enb, web, ssrb;
        logic [3:0] addrb;
        logic [3:0] dib;
        logic       exp_doa;
        logic [3:0] exp_dob;
        logic       exp_col;
    } vec_t;

    vec_t vecs[$];

    x_ramb_asym_dp_clr u_dut0 (
        .CLK(CLK), .RST(RST),
        .ADDRA(d0_addra), .DIA(d0_dia), .ENA(d0_ena), .WEA(d0_wea), .SSRA(d0_ssra), .DOA(d0_doa),
        .ADDRB(d0_addrb), .DIB(d0_dib), .ENB(d0_enb), .WEB(d0_web), .SSRB(d0_ssrb), .DOB(d0_dob),
        .BUSY(d0_busy), .COLLISION(d0_col)
    );

    x_ramb_asym_dp_clr #(
        .MEM_BITS(64), .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("READ_FIRST"),
        .INIT_B(4'h3), .SRVAL_B(4'h6), .CLEAR_ON_RESET(1'b0)
    ) u_dut1 (
        .CLK(CLK), .RST(RST),
        .ADDRA(d1_addra), .DIA(d1_dia), .ENA(d1_ena), .WEA(d1_wea), .SSRA(d1_ssra), .DOA(d1_doa),
        .ADDRB(d1_addrb), .DIB(d1_dib), .ENB(d1_enb), .WEB(d1_web), .SSRB(d1_ssrb), .DOB(d1_dob),
        .BUSY(d1_busy), .COLLISION(d1_col)
    );

    x_ramb_asym_dp_clr #(
        .MEM_BITS(64), .DOB_REG(1'b1), .SRVAL_B(4'h9), .CLEAR_VAL(1'b1)
    ) u_dut2 (
        .CLK(CLK), .RST(RST),
        .ADDRA(d2_addra), .DIA(d2_dia), .ENA(d2_ena), .WEA(d2_wea), .SSRA(d2_ssra), .DOA(d2_doa),
        .ADDRB(d2_addrb), .DIB(d2_dib), .ENB(d2_enb), .WEB(d2_web), .SSRB(d2_ssrb), .DOB(d2_dob),
        .BUSY(d2_busy), .COLLISION(d2_col)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        d1_ena   = v.ena;   d1_wea = v.wea; d1_ssra = v.ssra;
        d1_addra = v.addra; d1_dia = v.dia;
        d1_enb   = v.enb;   d1_web = v.web; d1_ssrb = v.ssrb;
        d1_addrb = v.addrb; d1_dib = v.dib;
    endtask

    task automatic d2Step(input logic en, input logic we, input logic ssr,
                          input logic [3:0] addr, input logic [3:0] di,
                          input logic [3:0] exp_dob, input string name);
        d2_enb = en; d2_web = we; d2_ssrb = ssr; d2_addrb = addr; d2_dib = di;
        @(posedge CLK);
        #1;
        checkOutput(name, 32'(d2_dob), 32'(exp_dob));
    endtask

    task automatic countSweep(input string name);
        int n;
        n = 0;
        while (d0_busy && n < 5000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checkOutput(name, 32'(n), 32'd4096);
    endtask

    // Fields: ena wea ssra addra dia | enb web ssrb addrb dib | doa dob col
    task automatic fillTable();
        vecs.push_back(vec_t'{1'b1,1'b1,1'b0,6'd0,1'b1, 1'b0,1'b0,1'b0,4'd0,4'h0, 1'b0,4'h3,1'b0});
        vecs.push_back(vec_t'{1'b1,1'b1,1'b0,6'd1,1'b0, 1'b0,1'b0,1'b0,4'd0,4'h0, 1'b0,4'h3,1'b0});
        vecs.push_back(vec_t'{1'b1,1'b1,1'b0,6'd2,1'b1, 1'b0,1'b0,1'b0,4'd0,4'h0, 1'b0,4'h3,1'b0});
        vecs.push_back(vec_t'{1'b1,1'b1,1'b0,6'd3,1'b1, 1'b0,1'b0,1'b0,4'd0,4'h0, 1'b0,4'h3,1'b0});
        vecs.push_back(vec_t'{1'b1,1'b0,1'b0,6'd0,1'b0, 1'b1,1'b0,1'b0,4'd0,4'h0, 1'b1,4'hD,1'b0});
        vecs.push_back(vec_t'{1'b0,1'b0,1'b0,6'd0,1'b0, 1'b1,1'b1,1'b0,4'd0,4'hA, 1'b1,4'hD,1'b0});
        vecs.push_back(vec_t'{1'b1,1'b0,1'b0,6'd0,1'b0, 1'b1,1'b1,1'b0,4'd0,4'h5, 1'b0,4'hA,1'b0});
        vecs.push_back(vec_t'{1'b1,1'b0,1'b0,6'd1,1'b0, 1'b1,1'b0,1'b0,4'd0,4'h0, 1'b0,4'h5,1'b0});
        vecs.push_back(vec_t'{1'b1,1'b0,1'b0,6'd2,1'b0, 1'b0,1'b0,1'b0,4'd0,4'h0, 1'b1,4'h5,1'b0});
        vecs.push_back(vec_t'{1'b1,1'b1,1'b0,6'd2,1'b1, 1'b1,1'b1,1'b0,4'd0,4'h0, 1'b1,4'h5,1'b1});
        vecs.push_back(vec_t'{1'b0,1'b0,1'b0,6'd0,1'b0, 1'b1,1'b0,1'b0,4'd0,4'h0, 1'b1,4'h0,1'b0});
        vecs.push_back(vec_t'{1'b1,1'b0,1'b1,6'd0,1'b0, 1'b0,1'b0,1'b0,4'd0,4'h0, 1'b0,4'h0,1'b0});
        vecs.push_back(vec_t'{1'b1,1'b0,1'b0,6'd2,1'b0, 1'b0,1'b0,1'b1,4'd0,4'h0, 1'b0,4'h0,1'b0});
        vecs.push_back(vec_t'{1'b1,1'b1,1'b1,6'd5,1'b1, 1'b0,1'b0,1'b0,4'd0,4'h0, 1'b0,4'h0,1'b0});
        vecs.push_back(vec_t'{1'b1,1'b0,1'b0,6'd5,1'b0, 1'b1,1'b1,1'b1,4'd0,4'h9, 1'b1,4'h6,1'b0});
        vecs.push_back(vec_t'{1'b0,1'b0,1'b0,6'd0,1'b0, 1'b1,1'b0,1'b0,4'd0,4'h0, 1'b1,4'h9,1'b0});
    endtask

    // Top-level test sequence.
    initial begin
        bit         model_mem [16384];
        logic       exp_doa, exp_col, rd_a;
        logic [3:0] exp_dob, rd_b;
        logic       ena, wea, ssra, dia, enb, web, ssrb;
        logic [3:0] dib;
        int         addra, addrb;

        checks = 0;
        errors = 0;
        fillTable();

        RST = 1'b1;
        {d0_addra, d0_dia, d0_ena, d0_wea, d0_ssra, d0_addrb, d0_dib, d0_enb, d0_web, d0_ssrb} = '0;
        {d1_addra, d1_dia, d1_ena, d1_wea, d1_ssra, d1_addrb, d1_dib, d1_enb, d1_web, d1_ssrb} = '0;
        {d2_addra, d2_dia, d2_ena, d2_wea, d2_ssra, d2_addrb, d2_dib, d2_enb, d2_web, d2_ssrb} = '0;
        repeat (3) @(negedge CLK);

        $display("[TB] reset values");
        checkOutput("rst.d0_busy", 32'(d0_busy), 32'd1);
        checkOutput("rst.d0_doa",  32'(d0_doa),  32'd0);
        checkOutput("rst.d0_dob",  32'(d0_dob),  32'd0);
        checkOutput("rst.d0_col",  32'(d0_col),  32'd0);
        checkOutput("rst.d1_busy", 32'(d1_busy), 32'd0);
        checkOutput("rst.d1_dob",  32'(d1_dob),  32'h3);
        checkOutput("rst.d2_busy", 32'(d2_busy), 32'd1);
        checkOutput("rst.d2_dob",  32'(d2_dob),  32'd0);

        RST = 1'b0;
        $display("[TB] full clear sweep");
        countSweep("sweep_len");
        checkOutput("d2_busy_done", 32'(d2_busy), 32'd0);

        $display("[TB] table vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge CLK);
            #1;
            checkOutput($sformatf("tab%0d.doa", i), 32'(d1_doa), 32'(vecs[i].exp_doa));
            checkOutput($sformatf("tab%0d.dob", i), 32'(d1_dob), 32'(vecs[i].exp_dob));
            checkOutput($sformatf("tab%0d.col", i), 32'(d1_col), 32'(vecs[i].exp_col));
        end
        applyStimulus(vec_t'{1'b0,1'b0,1'b0,6'd0,1'b0, 1'b0,1'b0,1'b0,4'd0,4'h0, 1'b0,4'h0,1'b0});

        $display("[TB] registered output sequence");
        d2_ena = 1'b1; d2_addra = 6'd4;
        d2Step(1'b1, 1'b1, 1'b0, 4'd1, 4'h6, 4'h0, "reg.e1");
        checkOutput("reg.doa_clear", 32'(d2_doa), 32'd1);
        d2_ena = 1'b0;
        d2Step(1'b1, 1'b0, 1'b0, 4'd0, 4'h0, 4'h6, "reg.e2");
        d2Step(1'b1, 1'b0, 1'b0, 4'd1, 4'h0, 4'hF, "reg.e3");
        d2Step(1'b1, 1'b0, 1'b1, 4'd0, 4'h0, 4'h9, "reg.e4");
        d2Step(1'b1, 1'b0, 1'b0, 4'd0, 4'h0, 4'hF, "reg.e5");
        d2Step(1'b0, 1'b0, 1'b0, 4'd1, 4'h0, 4'hF, "reg.e6");

        $display("[TB] randomized traffic against model");
        for (int k = 0; k < 16384; k++) model_mem[k] = 1'b0;
        exp_doa = 1'b0;
        exp_dob = 4'h0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            ena   = ($urandom_range(0, 3) != 0);
            wea   = 1'($urandom_range(0, 1));
            ssra  = ($urandom_range(0, 7) == 0);
            dia   = 1'($urandom_range(0, 1));
            addra = int'($urandom_range(0, 31));
            enb   = ($urandom_range(0, 3) != 0);
            web   = 1'($urandom_range(0, 1));
            ssrb  = ($urandom_range(0, 7) == 0);
            dib   = 4'($urandom_range(0, 15));
            addrb = int'($urandom_range(0, 7));
            d0_ena = ena; d0_wea = wea; d0_ssra = ssra; d0_dia = dia; d0_addra = 14'(addra);
            d0_enb = enb; d0_web = web; d0_ssrb = ssrb; d0_dib = dib; d0_addrb = 12'(addrb);

            rd_a = model_mem[addra];
            for (int k = 0; k < 4; k++) rd_b[k] = model_mem[addrb * 4 + k];
            if (ena) exp_doa = ssra ? 1'b0 : (wea ? dia : rd_a);
            if (enb) exp_dob = ssrb ? 4'h0 : (web ? dib : rd_b);
            exp_col = 1'b0;
            if (ena && wea && enb && web) begin
                for (int k = 0; k < 4; k++) begin
                    if (addrb * 4 + k == addra) exp_col = 1'b1;
                end
            end
            if (ena && wea) model_mem[addra] = dia;
            if (enb && web) begin
                for (int k = 0; k < 4; k++) model_mem[addrb * 4 + k] = dib[k];
            end

            @(posedge CLK);
            #1;
            checkOutput($sformatf("rnd%0d.doa", cyc), 32'(d0_doa), 32'(exp_doa));
            checkOutput($sformatf("rnd%0d.dob", cyc), 32'(d0_dob), 32'(exp_dob));
            checkOutput($sformatf("rnd%0d.col", cyc), 32'(d0_col), 32'(exp_col));
        end

        $display("[TB] reset during sweep");
        d0_ena = 1'b0; d0_enb = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        d0_ena = 1'b1; d0_wea = 1'b1; d0_ssra = 1'b0; d0_dia = 1'b1; d0_addra = 14'd0;
        d0_enb = 1'b1; d0_web = 1'b1; d0_ssrb = 1'b0; d0_dib = 4'hF; d0_addrb = 12'd5;
        repeat (100) @(posedge CLK);
        #1;
        checkOutput("mid.busy", 32'(d0_busy), 32'd1);
        checkOutput("mid.doa_hold", 32'(d0_doa), 32'd0);
        checkOutput("mid.dob_hold", 32'(d0_dob), 32'd0);
        RST = 1'b1;
        #1;
        checkOutput("mid.busy_rst", 32'(d0_busy), 32'd1);
        @(negedge CLK);
        RST = 1'b0;
        countSweep("restart_len");
        d0_ena = 1'b0; d0_wea = 1'b0; d0_enb = 1'b0; d0_web = 1'b0;

        $display("[TB] readback after sweep");
        for (int i = 0; i < 4096; i++) begin
            d0_enb   = 1'b1;
            d0_addrb = 12'(i);
            @(posedge CLK);
            #1;
            checkOutput($sformatf("clr.dob%0d", i), 32'(d0_dob), 32'd0);
        end
        d0_enb = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
